// File: rtl/pn_pkg.sv
// pn_pkg: shared opcodes, FSM state codes and mode encoding for the
// Polish-notation stack evaluator.
package pn_pkg;

  localparam int unsigned OPC_W = 3;
  localparam int unsigned ST_W  = 2;

  // Opcode values carried in the token field when operator = 1
  localparam logic [OPC_W-1:0] OP_ADD = 3'd0;
  localparam logic [OPC_W-1:0] OP_SUB = 3'd1;
  localparam logic [OPC_W-1:0] OP_MUL = 3'd2;
  localparam logic [OPC_W-1:0] OP_ABS = 3'd3;

  // FSM state codes
  localparam logic [ST_W-1:0] ST_IDLE = 2'd0;
  localparam logic [ST_W-1:0] ST_RECV = 2'd1;
  localparam logic [ST_W-1:0] ST_EVAL = 2'd2;
  localparam logic [ST_W-1:0] ST_OUT  = 2'd3;

  // Expression notation, latched with the first token
  localparam logic MODE_PREFIX  = 1'b0;
  localparam logic MODE_POSTFIX = 1'b1;

endpackage

// File: rtl/pn_stack_eval_if.sv
// pn_stack_eval_if: token input and result output handshake bundle.
// master = token source / result sink, slave = evaluator.
interface pn_stack_eval_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IN_W   = 3
);
  logic                     mode;
  logic                     in_valid;
  logic                     in_ready;
  logic                     operator;
  logic [IN_W-1:0]          in;
  logic                     in_last;
  logic                     out_valid;
  logic                     out_ready;
  logic signed [DATA_W-1:0] out;
  logic                     out_err;

  modport master (
    output mode, in_valid, operator, in, in_last, out_ready,
    input  in_ready, out_valid, out, out_err
  );

  modport slave (
    input  mode, in_valid, operator, in, in_last, out_ready,
    output in_ready, out_valid, out, out_err
  );
endinterface

// File: rtl/pn_alu.sv
// pn_alu: combinational operator unit for the PN evaluator.
// Optional feature: define PN_SAT_EN to clamp results to the signed
// DATA_W range instead of wrapping.
module pn_alu
  import pn_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IN_W   = 3
) (
  input  logic signed [DATA_W-1:0] op1,
  input  logic signed [DATA_W-1:0] op2,
  input  logic [IN_W-1:0]          opcode,
  output logic signed [DATA_W-1:0] result,
  output logic                     rsvd
);

`ifdef PN_SAT_EN
  // Wide enough for the exact product and for |sum| of two extremes
  localparam int unsigned WW = 2 * DATA_W + 2;
  localparam logic signed [WW-1:0] SMAX = {{(WW-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [WW-1:0] SMIN = {{(WW-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};
`else
  localparam int unsigned WW = DATA_W;
`endif

  logic signed [WW-1:0] a;
  logic signed [WW-1:0] b;
  logic signed [WW-1:0] sum;
  logic signed [WW-1:0] v;

  assign a   = WW'(op1);
  assign b   = WW'(op2);
  assign sum = a + b;

  // Opcode decode at working width; reserved codes yield 0
  always_comb begin
    rsvd = 1'b0;
    v    = '0;
    case (opcode)
      IN_W'(OP_ADD): v = sum;
      IN_W'(OP_SUB): v = a - b;
      IN_W'(OP_MUL): v = a * b;
      IN_W'(OP_ABS): v = sum[WW-1] ? -sum : sum;
      default:       rsvd = 1'b1;
    endcase
  end

  // Narrow to DATA_W: wrap by default, clamp when saturation is built in
  always_comb begin
    result = v[DATA_W-1:0];
`ifdef PN_SAT_EN
    if (v > SMAX) begin
      result = SMAX[DATA_W-1:0];
    end else if (v < SMIN) begin
      result = SMIN[DATA_W-1:0];
    end
`endif
  end

endmodule

// File: rtl/pn_stack_eval.sv
// pn_stack_eval: buffers one framed prefix/postfix token stream, evaluates
// it one token per cycle on an internal stack and returns a registered
// signed result with a sticky error flag. Saturation via PN_SAT_EN (pn_alu).
module pn_stack_eval
  import pn_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IN_W   = 3,
  parameter int unsigned DEPTH  = 16
) (
  input  logic             clk,
  input  logic             rst,
  pn_stack_eval_if.slave   bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned TOK_W = IN_W + 1;

  logic [ST_W-1:0]          state_q, state_d;
  logic                     mode_q, mode_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [CNT_W-1:0]         rem_q, rem_d;
  logic [CNT_W-1:0]         sp_q, sp_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     err_q, err_d;
  logic                     in_ready_q, in_ready_d;
  logic                     out_valid_q, out_valid_d;
  logic                     out_err_q, out_err_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic [TOK_W-1:0]         buf_q [DEPTH];
  logic [TOK_W-1:0]         buf_d [DEPTH];
  logic signed [DATA_W-1:0] stk_q [DEPTH];
  logic signed [DATA_W-1:0] stk_d [DEPTH];

  logic                     xfer;
  logic [TOK_W-1:0]         tok;
  logic [TOK_W-1:0]         cur;
  logic                     go_eval;
  logic                     fin_err;
  logic signed [DATA_W-1:0] tos, nos;
  logic signed [DATA_W-1:0] alu_op1, alu_op2, alu_res;
  logic                     alu_rsvd;

  assign xfer = bus.in_valid & bus.in_ready;
  assign tok  = {bus.operator, bus.in};
  assign cur  = buf_q[idx_q];

  assign bus.in_ready  = in_ready_q & ~rst;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.out_err   = out_err_q;

  // Top two stack entries, ordered into operands by the latched notation
  always_comb begin
    tos = stk_q[IDX_W'(sp_q - CNT_W'(1))];
    nos = stk_q[IDX_W'(sp_q - CNT_W'(2))];
    if (mode_q == MODE_POSTFIX) begin
      alu_op1 = nos;
      alu_op2 = tos;
    end else begin
      alu_op1 = tos;
      alu_op2 = nos;
    end
  end

  pn_alu #(
    .DATA_W (DATA_W),
    .IN_W   (IN_W)
  ) u_alu (
    .op1    (alu_op1),
    .op2    (alu_op2),
    .opcode (cur[IN_W-1:0]),
    .result (alu_res),
    .rsvd   (alu_rsvd)
  );

  // Next-state, buffer/stack update and result capture
  always_comb begin
    state_d     = state_q;
    mode_d      = mode_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    sp_d        = sp_q;
    idx_d       = idx_q;
    err_d       = err_q;
    out_valid_d = out_valid_q;
    out_err_d   = out_err_q;
    out_d       = out_q;
    buf_d       = buf_q;
    stk_d       = stk_q;
    go_eval     = 1'b0;
    fin_err     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (xfer) begin
          mode_d   = bus.mode;
          buf_d[0] = tok;
          cnt_d    = CNT_W'(1);
          sp_d     = '0;
          err_d    = 1'b0;
          state_d  = ST_RECV;
          go_eval  = bus.in_last;
        end
      end
      ST_RECV: begin
        if (xfer) begin
          if (cnt_q < CNT_W'(DEPTH)) begin
            buf_d[IDX_W'(cnt_q)] = tok;
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            err_d = 1'b1;
          end
          go_eval = bus.in_last;
        end
      end
      ST_EVAL: begin
        if (rem_q == '0) begin
          fin_err     = err_q | (sp_q != CNT_W'(1));
          state_d     = ST_OUT;
          out_valid_d = 1'b1;
          out_err_d   = fin_err;
          out_d       = fin_err ? '0 : stk_q[0];
        end else begin
          rem_d = rem_q - CNT_W'(1);
          idx_d = (mode_q == MODE_POSTFIX) ? idx_q + IDX_W'(1) : idx_q - IDX_W'(1);
          if (!cur[IN_W]) begin
            if (sp_q < CNT_W'(DEPTH)) begin
              stk_d[IDX_W'(sp_q)] = DATA_W'(cur[IN_W-1:0]);
              sp_d = sp_q + CNT_W'(1);
            end else begin
              err_d = 1'b1;
            end
          end else if (sp_q < CNT_W'(2)) begin
            err_d = 1'b1;
          end else begin
            stk_d[IDX_W'(sp_q - CNT_W'(2))] = alu_res;
            sp_d = sp_q - CNT_W'(1);
            if (alu_rsvd) begin
              err_d = 1'b1;
            end
          end
        end
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          state_d     = ST_IDLE;
          out_valid_d = 1'b0;
          out_d       = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Framing closed: set up the walk order over the stored tokens
    if (go_eval) begin
      state_d = ST_EVAL;
      rem_d   = cnt_d;
      idx_d   = (mode_d == MODE_POSTFIX) ? '0 : IDX_W'(cnt_d - CNT_W'(1));
    end

    in_ready_d = (state_d == ST_IDLE) || (state_d == ST_RECV);
  end

  // Control and result registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mode_q      <= MODE_PREFIX;
      cnt_q       <= '0;
      rem_q       <= '0;
      sp_q        <= '0;
      idx_q       <= '0;
      err_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_err_q   <= 1'b0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      mode_q      <= mode_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      sp_q        <= sp_d;
      idx_q       <= idx_d;
      err_q       <= err_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_err_q   <= out_err_d;
      out_q       <= out_d;
    end
  end

  // Token buffer and stack storage; contents are qualified by cnt/sp
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
    stk_q <= stk_d;
  end

endmodule

// File: doc/pn_stack_eval.md
# pn_stack_eval

Parametrised Polish-notation evaluator for prefix and postfix expressions. It is the next generation of the fixed 12-token PN block. It accepts a token stream with explicit framing and back-pressure, buffers up to DEPTH tokens, and evaluates them one token per cycle on an internal stack. It then presents one signed result with an error flag through a valid/ready output port. It sits between the token front-end and the result collector in the PN datapath.

## Interface
- DATA_W, 32: width of the stack, the arithmetic and `out`. Minimum 8.
- IN_W, 3: token width. Operand tokens are unsigned and zero-extended to DATA_W.
- DEPTH, 16: maximum number of tokens per expression, and also the stack depth.
- clk  in  1  single clock; everything is on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- mode  in  1  0 = prefix, 1 = postfix. Sampled only with the first token of an expression.
- in_valid  in  1  token present.
- in_ready  out  1  block can accept a token.
- operator  in  1  1 = `in` is an opcode, 0 = `in` is an operand.
- in  in  IN_W  token value.
- in_last  in  1  marks the final token of the expression.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts the result.
- out  out  DATA_W  signed result.
- out_err  out  1  the expression was malformed. When it is 1, `out` is 0.

## Operation
- A token is transferred on any edge where in_valid and in_ready are both 1.
- States:
  - IDLE: in_ready = 1. The first transfer latches mode, stores token 0 and moves to RECV. If that token also has in_last = 1, it moves directly to EVAL.
  - RECV: in_ready = 1. Each transfer stores the token at index cnt and increments cnt. A transfer with in_last = 1 moves to EVAL.
  - EVAL: in_ready = 0. Exactly one buffered token is processed per cycle. Prefix walks the buffer from index cnt-1 down to 0; postfix walks it from 0 up to cnt-1. After the last token has been processed, the state moves to OUT.
  - OUT: out_valid = 1. `out` and out_err are held stable until out_ready = 1, then the state returns to IDLE.
- Operand token: push the zero-extended value.
- Operator token: pop two entries.
  - Prefix: op1 is the first pop (top of stack), op2 is the second.
  - Postfix: op2 is the first pop, op1 is the second.
  - The result is pushed.
- Opcodes:
  - 0: op1 + op2
  - 1: op1 − op2
  - 2: op1 × op2, truncated to DATA_W (or saturated, see Configuration)
  - 3: |op1 + op2|
  - 4–7: reserved. Push 0 and set the error flag.
- Errors are sticky for the current expression:
  - an operator arrives with fewer than 2 stack entries (underflow): the stack is unchanged;
  - more than DEPTH tokens arrive: the extra tokens are dropped, but the transfer still completes and in_last still ends framing;
  - the final stack count is not 1;
  - a reserved opcode is used.
- Without PN_SAT_EN, arithmetic wraps modulo 2^DATA_W. |most-negative| stays most-negative.

## Timing
- Reset values: in_ready = 0 while rst = 1 and 1 on the first cycle after reset. out_valid = 0, out = 0, out_err = 0. State = IDLE; cnt, stack pointer and error flag are cleared.
- rst asserted in any state, including mid-EVAL or OUT with out_ready = 0, discards the expression. No result is produced.
- Latency: the last token transfers at edge T for N stored tokens. out_valid rises after edge T+N+1, which is N+1 cycles later.
- The result is registered; `out` and out_err change only on entry to OUT.
- Edge T+k, with out_valid and out_ready both 1, is the handshake edge. At T+k, out_valid drops, `out` returns to 0 and in_ready rises. The next expression transfers no earlier than edge T+k+1.
- In_valid while in_ready = 0 is ignored. No token is lost that the source was not told was accepted.

## Configuration
- PN_SAT_EN defined: add, sub, mul and abs results clamp to [−2^(DATA_W−1), 2^(DATA_W−1)−1]. |most-negative| becomes the maximum positive value.
- PN_SAT_EN undefined: plain two's-complement wrap, as described in Operation.

## Structure
- Package pn_pkg holds the opcode localparams (OP_ADD, OP_SUB, OP_MUL, OP_ABS), the state enum (IDLE, RECV, EVAL, OUT) and the mode encoding.
- Sub-module pn_alu is combinational. It takes op1, op2 and opcode, produces result and reserved-opcode flag, and contains the PN_SAT_EN logic.
- The top level holds the token buffer, the stack, the counters and the FSM.

## Test plan
- Postfix 3 4 + 2 × (tokens 3, 4, op0, 2, op2), default parameters → out = 14, out_err = 0, out_valid 6 cycles after the last transfer.
- Prefix − 5 × 2 3 (op1, 5, op2, 2, 3) → out = −1, out_err = 0.
- Postfix 1 7 − 2 |+| (1, 7, op1, 2, op3) → out = 4. Postfix 3 + → out_err = 1, out = 0. Opcode 5 anywhere → out_err = 1.
- DATA_W = 8, postfix 7 7 × 7 × 7 × → 127 with PN_SAT_EN; 97 without it.
- DEPTH = 4, send 6 tokens → out_err = 1. Hold out_ready = 0 for 5 cycles → out stable and in_ready = 0 throughout; in_ready rises only on the handshake edge.
- Assert rst for 1 cycle during EVAL → out_valid never rises. A following postfix 2 3 × → out = 6.
